// File: rtl/mips_mc_control.sv
// mips_mc_control: multicycle MIPS control FSM.
// Steps each instruction through fetch, decode, execute, memory and writeback,
// and drives the datapath mux selects and enables.
// Optional feature macro: MIPS_CTRL_MEMWAIT_EN. When it is defined, FETCH, MEMRD
// and MEMWR stall until mem_ready=1. When it is undefined, mem_ready is ignored.
//
// state      | code | meaning
// -----------+------+--------------------------------------------------
// S_IDLE     |  0   | reset state, all outputs low
// S_FETCH    |  1   | read instruction, load IR, PC <= PC + 4
// S_DECODE   |  2   | branch target into ALUOut, dispatch on opcode
// S_MEMADR   |  3   | load/store address = regA + signext imm
// S_MEMRD    |  4   | memory read at ALUOut
// S_MEMWB    |  5   | MDR -> rt
// S_MEMWR    |  6   | memory write at ALUOut
// S_EXEC     |  7   | R-type ALU operation
// S_ALUWB    |  8   | ALUOut -> rd
// S_BRANCH   |  9   | compare regA/regB, take branch on zero
// S_JUMP     | 10   | PC <= jump target
// S_ADDIEX   | 11   | regA + signext imm
// S_ADDIWB   | 12   | ALUOut -> rt
module mips_mc_control #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_J     = 6'h02,
  parameter logic [5:0] OP_ADDI  = 6'h08
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
  } state_t;

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   pc_write;
  logic   branch;
  logic   mem_ok;

`ifdef MIPS_CTRL_MEMWAIT_EN
  assign mem_ok = mem_ready;
`else
  // Without the wait feature every memory access completes in one cycle.
  logic mem_ready_unused;
  assign mem_ready_unused = mem_ready;
  assign mem_ok = 1'b1;
`endif

  // State register and sticky illegal-opcode flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic and decode of the datapath controls from the current state
  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    pc_write   = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // The IR and PC update only in the cycle the memory returns data.
        if (mem_ok) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEMADR;
        else if (opcode == OP_RTYPE)            state_d = S_EXEC;
        else if (opcode == OP_BEQ)              state_d = S_BRANCH;
        else if (opcode == OP_J)                state_d = S_JUMP;
        else if (opcode == OP_ADDI)             state_d = S_ADDIEX;
        else begin
          state_d   = S_FETCH;
          illegal_d = 1'b1;
        end
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ok) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ok) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        branch    = 1'b1;
        pc_src    = 2'b01;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        state_d  = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      // Unused codes recover to FETCH with every output held low.
      default: state_d = S_FETCH;
    endcase
  end

  assign pc_en      = pc_write | (branch & zero);
  assign illegal_op = illegal_q;
  assign state      = state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Randomized bench for mips_mc_control with an instruction-level reference model.
module tb_mips_mc_control;

`ifdef MIPS_CTRL_MEMWAIT_EN
  localparam bit MEMWAIT = 1'b1;
`else
  localparam bit MEMWAIT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
  logic       reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  mips_mc_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected controls for a state, built from the per-state output lists.
  function automatic logic [14:0] exp_outs(input int st, input logic z, input logic mr);
    logic pcw, br, io, mrd, mwr, irw, rdst, m2r, rw, asa;
    logic [1:0] asb, aop, psrc;
    {pcw, br, io, mrd, mwr, irw, rdst, m2r, rw, asa} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      1:  begin mrd = 1; asb = 2'b01; irw = mr || !MEMWAIT; pcw = irw; end
      2:  asb = 2'b11;
      3:  begin asa = 1; asb = 2'b10; end
      4:  begin io = 1; mrd = 1; end
      5:  begin rw = 1; m2r = 1; end
      6:  begin io = 1; mwr = 1; end
      7:  begin asa = 1; aop = 2'b10; end
      8:  begin rw = 1; rdst = 1; end
      9:  begin asa = 1; aop = 2'b01; br = 1; psrc = 2'b01; end
      10: begin pcw = 1; psrc = 2'b10; end
      11: begin asa = 1; asb = 2'b10; end
      12: rw = 1;
      default: ;
    endcase
    return {pcw | (br & z), io, mrd, mwr, irw, rdst, m2r, rw, asa, asb, aop, psrc};
  endfunction

  function automatic int cpi(input logic [5:0] op);
    case (op)
      6'h00: return 4;
      6'h23: return 5;
      6'h2B: return 4;
      6'h04: return 3;
      6'h02: return 3;
      6'h08: return 4;
      default: return 2;
    endcase
  endfunction

  function automatic logic [5:0] pick_opcode();
    logic [5:0] legal [6];
    logic [5:0] op;
    legal = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
    if ($urandom_range(0, 6) != 6) return legal[$urandom_range(0, 5)];
    op = 6'($urandom);
    while (cpi(op) != 2) op = 6'($urandom);
    return op;
  endfunction

  logic [14:0] got_outs;
  assign got_outs = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                     reg_write, alu_src_a, alu_src_b, alu_op, pc_src};

  int         exp_st;
  int         nxt;
  logic       exp_ill, ill_next;
  int         plan[$];
  int         inst_cycles;
  logic [5:0] cur_op;
  bit         stall;

  initial begin
    rst_n = 1'b1; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk); #1;
    check("reset_outs", 32'(got_outs), 32'd0);
    check("reset_state", 32'(state), 32'd0);
    check("reset_illegal", 32'(illegal_op), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_st = 0; exp_ill = 1'b0; inst_cycles = 0; cur_op = 6'h00;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      // Occasional reset mid-instruction must clear everything at once.
      if (cyc > 20 && exp_st > 1 && $urandom_range(0, 59) == 0) begin
        rst_n = 1'b0;
        #1;
        check("midrst_outs", 32'(got_outs), 32'd0);
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_illegal", 32'(illegal_op), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_st = 0; exp_ill = 1'b0; inst_cycles = 0;
        plan.delete();
        continue;
      end

      zero      = 1'($urandom);
      mem_ready = ($urandom_range(0, 9) < 6);
      if (exp_st == 1) begin
        opcode = pick_opcode();
        cur_op = opcode;
      end
      #1;
      check($sformatf("outs_st%0d", exp_st), 32'(got_outs), 32'(exp_outs(exp_st, zero, mem_ready)));
      check("state", 32'(state), 32'(exp_st));
      check("illegal", 32'(illegal_op), 32'(exp_ill));

      ill_next = exp_ill;
      stall = MEMWAIT && (exp_st == 1 || exp_st == 4 || exp_st == 6) && !mem_ready;
      if (exp_st != 0 && !stall) inst_cycles++;
      if (exp_st == 0) nxt = 1;
      else if (stall) nxt = exp_st;
      else if (exp_st == 1) nxt = 2;
      else begin
        if (exp_st == 2) begin
          case (opcode)
            6'h00: plan = '{7, 8};
            6'h23: plan = '{3, 4, 5};
            6'h2B: plan = '{3, 6};
            6'h04: plan = '{9};
            6'h02: plan = '{10};
            6'h08: plan = '{11, 12};
            default: begin plan.delete(); ill_next = 1'b1; end
          endcase
        end
        nxt = (plan.size() > 0) ? plan.pop_front() : 1;
      end
      if (nxt == 1 && exp_st > 1) begin
        check($sformatf("cpi_op%0h", cur_op), 32'(inst_cycles), 32'(cpi(cur_op)));
        inst_cycles = 0;
      end

      @(negedge clk);
      exp_st  = nxt;
      exp_ill = ill_next;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
